// File: rtl/controle_botoes.sv
// controle_botoes: synchronizes and debounces the four push-buttons, emits a
// one-cycle pulse per debounced press and holds a one-hot map selection that
// survives button release. All outputs are registered.
module controle_botoes #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] sel,
    output logic [3:0] press,
    output logic [3:0] estavel
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; synchronizer flops start here so no
    // phantom press is seen when reset is released.
    localparam logic [3:0]       RELEASED = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic {
        VAZIO,
        SELECIONADO
    } state_t;

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       btn_sync;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       estavel_d;
    logic [3:0]       rise;
    state_t           state;
    state_t           state_next;
    logic [3:0]       sel_next;

    // One-hot of the lowest set bit (0000 when nothing is set).
    function automatic logic [3:0] lowest_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // Two-flop synchronizer for the asynchronous button levels.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_p0 <= RELEASED;
            sync_p1 <= RELEASED;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Normalize to active-high: 1 means pressed from here on.
    always_comb begin
        btn_sync = BTN_ACTIVE_LOW ? ~sync_p1 : sync_p1;
    end

    // Per-button debouncer: the stable level flips only after the synchronized
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            estavel <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] == estavel[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERMINAL) begin
                    estavel[i] <= ~estavel[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level; registered into press below.
    always_comb begin
        rise = estavel & ~estavel_d;
    end

    // Edge-detect history and registered press pulses.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            estavel_d <= '0;
            press     <= '0;
        end else begin
            estavel_d <= estavel;
            press     <= rise;
        end
    end

    // Selection FSM next state: driven by the same vector that becomes press,
    // so sel and press update on the same edge.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        if (rise != 4'b0000) begin
            case (state)
                VAZIO: begin
                    state_next = SELECIONADO;
                    sel_next   = lowest_bit(rise);
                end
                SELECIONADO: begin
                    if ((rise & ~sel) != 4'b0000) begin
                        // Another button wins, even if the selected one also pulsed.
                        sel_next = lowest_bit(rise & ~sel);
                    end else begin
                        // Only the selected button pulsed: toggle off.
                        state_next = VAZIO;
                        sel_next   = 4'b0000;
                    end
                end
                default: begin
                    state_next = VAZIO;
                    sel_next   = 4'b0000;
                end
            endcase
        end
    end

    // Selection FSM state and held selection registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state <= VAZIO;
            sel   <= 4'b0000;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

endmodule

// File: tb/tb_controle_botoes.sv
// Testbench for controle_botoes: directed test-plan scenarios followed by
// randomized button activity, all checked every cycle against a window-based
// reference model of debounce, press and selection behaviour.
module tb_controle_botoes;

    localparam int D = 4;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] btn      = 4'hF;
    logic [3:0] sel;
    logic [3:0] press;
    logic [3:0] estavel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock_in = ~clock_in;

    controle_botoes #(
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clock_in(clock_in),
        .reset   (reset),
        .btn     (btn),
        .sel     (sel),
        .press   (press),
        .estavel (estavel)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the pressed-level vector seen at the latest edge; the
    // debouncer acts on values two edges old, so a button's stable level flips
    // when hist[2..D+1] all disagree with it.
    logic [3:0] hist[$];
    logic [3:0] m_est, m_press, m_sel, m_rise;

    function automatic logic [3:0] first_of(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                r    = 4'b0000;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < D + 2; k++) hist.push_back(4'b0000);
        m_est   = 4'b0000;
        m_press = 4'b0000;
        m_sel   = 4'b0000;
        m_rise  = 4'b0000;
    endtask

    task automatic model_step(input logic [3:0] pressed);
        logic [3:0] new_est;
        logic [3:0] h;
        logic       all_diff;
        hist.push_front(pressed);
        while (hist.size() > D + 2) void'(hist.pop_back());
        m_press = m_rise;
        new_est = m_est;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                h = hist[k];
                if (h[i] == m_est[i]) all_diff = 1'b0;
            end
            if (all_diff) new_est[i] = ~m_est[i];
        end
        m_rise = new_est & ~m_est;
        m_est  = new_est;
        if (m_press != 4'b0000) begin
            if (m_sel == 4'b0000)
                m_sel = first_of(m_press);
            else if ((m_press & ~m_sel) != 4'b0000)
                m_sel = first_of(m_press & ~m_sel);
            else
                m_sel = 4'b0000;
        end
    endtask

    always @(posedge clock_in or posedge reset) begin
        if (reset) model_reset();
        else       model_step(~btn);
    end

    // ---------------- stimulus helpers ----------------
    int pulses_seen;

    task automatic cyc();
        @(negedge clock_in);
        chk("sel", sel, m_sel);
        chk("press", press, m_press);
        chk("estavel", estavel, m_est);
        if (press != 4'b0000) pulses_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Press the given buttons (active-low), hold, then release everything.
    task automatic tap(input logic [3:0] which);
        btn = ~which;
        run(10);
        btn = 4'hF;
        run(10);
    endtask

    int hold_left [4];

    initial begin
        // Reset with all buttons released.
        btn = 4'hF;
        #1 reset = 1'b1;
        #2;
        chk("rst_sel", sel, 4'b0000);
        chk("rst_press", press, 4'b0000);
        chk("rst_est", estavel, 4'b0000);
        @(negedge clock_in);
        reset = 1'b0;
        run(20);
        chk("idle_sel", sel, 4'b0000);
        chk("idle_est", estavel, 4'b0000);

        // Clean press of btn1.
        btn = 4'b1101;
        run(5);
        chk("clean_est_early", estavel, 4'b0000);
        cyc();
        chk("clean_est", estavel, 4'b0010);
        chk("clean_nopulse_yet", press, 4'b0000);
        cyc();
        chk("clean_press", press, 4'b0010);
        chk("clean_sel", sel, 4'b0010);
        cyc();
        chk("clean_press_end", press, 4'b0000);
        btn = 4'hF;
        pulses_seen = 0;
        run(12);
        chk("release_sel", sel, 4'b0010);
        chk("release_est", estavel, 4'b0000);
        n_cmp++;
        if (pulses_seen != 0) begin
            n_err++;
            $display("FAIL release_pulses: got %0d expected 0", pulses_seen);
        end

        // Bounce rejection on btn2.
        pulses_seen = 0;
        for (int i = 0; i < 10; i++) begin
            btn[2] = ~btn[2];
            run(2);
        end
        btn = 4'hF;
        run(8);
        chk("bounce_sel", sel, 4'b0010);
        chk("bounce_est", estavel, 4'b0000);
        btn = 4'b1011;
        run(10);
        chk("bounce_hold_sel", sel, 4'b0100);
        n_cmp++;
        if (pulses_seen != 1) begin
            n_err++;
            $display("FAIL bounce_pulses: got %0d expected 1", pulses_seen);
        end
        btn = 4'hF;
        run(10);

        // Switch back to btn1, then btn3, toggle-off, btn0.
        tap(4'b0010);
        chk("sw_b1", sel, 4'b0010);
        tap(4'b1000);
        chk("sw_b3", sel, 4'b1000);
        tap(4'b1000);
        chk("toggle_off", sel, 4'b0000);
        tap(4'b0001);
        chk("sw_b0", sel, 4'b0001);
        tap(4'b0001);
        chk("vazio_again", sel, 4'b0000);

        // Simultaneous presses.
        tap(4'b0101);
        chk("simul_sel", sel, 4'b0001);
        tap(4'b1001);
        chk("simul_other_wins", sel, 4'b1000);

        // Reset mid-debounce while btn1 is held.
        btn = 4'b1101;
        run(2);
        reset = 1'b1;
        #1;
        chk("async_rst_sel", sel, 4'b0000);
        chk("async_rst_est", estavel, 4'b0000);
        run(2);
        reset = 1'b0;
        pulses_seen = 0;
        run(6);
        chk("mid_rst_nopulse", press, 4'b0000);
        cyc();
        chk("mid_rst_press", press, 4'b0010);
        chk("mid_rst_sel", sel, 4'b0010);
        run(10);
        n_cmp++;
        if (pulses_seen != 1) begin
            n_err++;
            $display("FAIL mid_rst_pulses: got %0d expected 1", pulses_seen);
        end
        btn = 4'hF;
        run(10);

        // Randomized activity with occasional resets.
        for (int b = 0; b < 4; b++) hold_left[b] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_left[b] == 0) begin
                    btn[b]       = 1'($urandom_range(0, 1));
                    hold_left[b] = int'($urandom_range(1, 12));
                end else begin
                    hold_left[b]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand_async_rst", press | sel | estavel, 4'b0000);
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
